// File: rtl/cla16_nibble_sequencer_pkg.sv
// Shared definitions for the nibble-serial 16-bit add/subtract unit.
//   - OP encodings presented on the OP port
//   - FSM state encodings
//   - NIBBLE_W: width of the single carry-lookahead slice
package cla16_nibble_sequencer_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // SUB and SBB are computed as A + ~B + carry-in.
  function automatic logic op_inverts_b(input op_e op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

endpackage

// File: rtl/cla16_nibble_sequencer_cla_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
// Ports:
//   a, b  in  4  addend nibbles
//   c0    in  1  carry into bit 0
//   sum   out 4  a + b + c0 (low 4 bits)
//   cout  out 1  carry out of bit 3
module cla16_nibble_sequencer_cla_slice
  import cla16_nibble_sequencer_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c0,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] c;   // c[i] is the carry into bit i

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead terms: every carry depends only on g, p and c0.
  assign c[0] = c0;
  assign c[1] = g[0] | (p[0] & c0);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

  generate
    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_sum
      assign sum[gi] = p[gi] ^ c[gi];
    end
  endgenerate

endmodule

// File: rtl/cla16_nibble_sequencer.sv
// Multi-cycle add/subtract unit: one 4-bit CLA slice processes one nibble
// per clock, LSB nibble first, with the inter-nibble carry registered.
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   IN_VALID / IN_READY   operand handshake (ready only in IDLE)
//   OP, A, B, CIN         operation, operands, carry-in for ADC/SBB
//   OUT_VALID / OUT_READY result handshake (valid only in DONE)
//   RESULT, COUT, OVERFLOW, ZERO  result and flags, held while OUT_VALID
// WIDTH must be a multiple of 4.
module cla16_nibble_sequencer
  import cla16_nibble_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             COUT,
  output logic             OVERFLOW,
  output logic             ZERO
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_e             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [WIDTH-1:0]   opa_reg, opa_next;
  logic [WIDTH-1:0]   beff_reg, beff_next;
  logic               carry_reg, carry_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic               cout_reg, cout_next;
  logic               ovf_reg, ovf_next;
  logic               zero_reg, zero_next;
  logic               out_valid_reg, out_valid_next;

  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic [WIDTH-1:0]    result_upd;

  cla16_nibble_sequencer_cla_slice u_cla_slice (
    .a    (opa_reg[idx_reg*NIBBLE_W +: NIBBLE_W]),
    .b    (beff_reg[idx_reg*NIBBLE_W +: NIBBLE_W]),
    .c0   (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Result with the current nibble replaced; on the last RUN edge this is
  // the complete answer the flags are derived from.
  always_comb begin
    result_upd = result_reg;
    result_upd[idx_reg*NIBBLE_W +: NIBBLE_W] = slice_sum;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      opa_reg       <= '0;
      beff_reg      <= '0;
      carry_reg     <= 1'b0;
      result_reg    <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      zero_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      opa_reg       <= opa_next;
      beff_reg      <= beff_next;
      carry_reg     <= carry_next;
      result_reg    <= result_next;
      cout_reg      <= cout_next;
      ovf_reg       <= ovf_next;
      zero_reg      <= zero_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    opa_next       = opa_reg;
    beff_next      = beff_reg;
    carry_next     = carry_reg;
    result_next    = result_reg;
    cout_next      = cout_reg;
    ovf_next       = ovf_reg;
    zero_next      = zero_reg;
    out_valid_next = out_valid_reg;
    IN_READY       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        IN_READY = 1'b1;
        idx_next = '0;
        if (IN_VALID) begin
          opa_next  = A;
          beff_next = op_inverts_b(op_e'(OP)) ? ~B : B;
          case (op_e'(OP))
            OP_ADD:  carry_next = 1'b0;
            OP_SUB:  carry_next = 1'b1;
            default: carry_next = CIN;   // ADC and SBB
          endcase
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        result_next = result_upd;
        carry_next  = slice_cout;
        idx_next    = idx_reg + IDX_W'(1);
        if (idx_reg == IDX_LAST) begin
          idx_next       = '0;
          cout_next      = slice_cout;
          // Same-sign inputs producing a differently signed result.
          ovf_next       = (opa_reg[WIDTH-1] ~^ beff_reg[WIDTH-1])
                         & (result_upd[WIDTH-1] ^ opa_reg[WIDTH-1]);
          zero_next      = (result_upd == '0);
          out_valid_next = 1'b1;
          state_next     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (OUT_READY) begin
          out_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        state_next     = ST_IDLE;
        out_valid_next = 1'b0;
        idx_next       = '0;
      end
    endcase
  end

  assign OUT_VALID = out_valid_reg;
  assign RESULT    = result_reg;
  assign COUT      = cout_reg;
  assign OVERFLOW  = ovf_reg;
  assign ZERO      = zero_reg;

endmodule

// File: tb/tb_cla16_nibble_sequencer.sv
module tb_cla16_nibble_sequencer;
  import cla16_nibble_sequencer_pkg::*;

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        CLK;
  logic        RESET_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [1:0]  OP;
  logic [15:0] A;
  logic [15:0] B;
  logic        CIN;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] RESULT;
  logic        COUT;
  logic        OVERFLOW;
  logic        ZERO;

  int   passed;
  int   total;
  exp_t sb[$];

  cla16_nibble_sequencer #(.WIDTH(16)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OP        (OP),
    .A         (A),
    .B         (B),
    .CIN       (CIN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .RESULT    (RESULT),
    .COUT      (COUT),
    .OVERFLOW  (OVERFLOW),
    .ZERO      (ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic cin);
    logic [15:0] bb;
    logic        c;
    logic [16:0] s;
    exp_t        e;
    bb     = (op == OP_SUB || op == OP_SBB) ? ~b : b;
    c      = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
    s      = {1'b0, a} + {1'b0, bb} + {16'b0, c};
    e.res  = s[15:0];
    e.cout = s[16];
    e.ovf  = (a[15] == bb[15]) && (s[15] != a[15]);
    e.zero = (s[15:0] == 16'h0000);
    return e;
  endfunction

  // Called #1 after a rising edge with the DUT in IDLE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic cin, input exp_t e, input int hold);
    int   lat;
    exp_t got;
    check($sformatf("%s_in_ready", tag), IN_READY, 1);
    sb.push_back(e);
    IN_VALID = 1'b1; OP = op; A = a; B = b; CIN = cin;
    @(posedge CLK); #1;
    // Operands were captured; scramble the inputs to show they are ignored.
    IN_VALID = 1'b0; A = 16'($urandom); B = 16'($urandom);
    OP = 2'($urandom); CIN = 1'($urandom);
    lat = 0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge CLK); #1;
      if (OUT_VALID === 1'b1) begin
        lat = n;
        break;
      end
    end
    check($sformatf("%s_latency", tag), lat, 4);
    check($sformatf("%s_sb_nonempty", tag), (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check($sformatf("%s_result", tag), RESULT, got.res);
      check($sformatf("%s_cout", tag), COUT, got.cout);
      check($sformatf("%s_overflow", tag), OVERFLOW, got.ovf);
      check($sformatf("%s_zero", tag), ZERO, got.zero);
      for (int h = 0; h < hold; h++) begin
        IN_VALID = ~IN_VALID; A = 16'($urandom); B = 16'($urandom);
        @(posedge CLK); #1;
        check($sformatf("%s_hold%0d_result", tag, h), RESULT, got.res);
        check($sformatf("%s_hold%0d_flags", tag, h), {COUT, OVERFLOW, ZERO},
              {got.cout, got.ovf, got.zero});
        check($sformatf("%s_hold%0d_valid", tag, h), OUT_VALID, 1);
        check($sformatf("%s_hold%0d_in_ready", tag, h), IN_READY, 0);
      end
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    check($sformatf("%s_released_valid", tag), OUT_VALID, 0);
    check($sformatf("%s_released_in_ready", tag), IN_READY, 1);
    $display("op=%0d a=%04h b=%04h cin=%0b -> result=%04h cout=%0b ovf=%0b zero=%0b latency=%0d",
             op, a, b, cin, RESULT, COUT, OVERFLOW, ZERO, lat);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [15:0] ra, rb;
    logic        rc;
    logic        saw_valid;
    passed = 0; total = 0;
    RESET_N = 1'b0; IN_VALID = 1'b0; OP = 2'b00; A = '0; B = '0; CIN = 1'b0;
    OUT_READY = 1'b0;
    #3;
    check("reset_result", RESULT, 0);
    check("reset_flags", {COUT, OVERFLOW, ZERO}, 0);
    check("reset_out_valid", OUT_VALID, 0);
    check("reset_in_ready", IN_READY, 1);
    @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    run_op("add_5555", OP_ADD, 16'h1234, 16'h4321, 1'b0, '{16'h5555, 1'b0, 1'b0, 1'b0}, 0);
    run_op("add_ripple", OP_ADD, 16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1}, 0);
    run_op("add_ovf_bp", OP_ADD, 16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0}, 5);
    run_op("sub_borrow", OP_SUB, 16'h0005, 16'h0007, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0}, 0);
    run_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b1, 1'b1, 1'b0}, 0);
    run_op("adc_cin", OP_ADC, 16'hFFFF, 16'h0000, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1}, 0);
    run_op("sbb_cin0", OP_SBB, 16'h0010, 16'h0001, 1'b0, '{16'h000E, 1'b1, 1'b0, 1'b0}, 0);

    for (int i = 0; i < 4; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      run_op($sformatf("rand%0d", i), rop, ra, rb, rc, model(rop, ra, rb, rc), 0);
    end

    // Abort an operation after two RUN edges.
    sb.push_back(model(OP_ADD, 16'h1234, 16'h1111, 1'b0));
    IN_VALID = 1'b1; OP = OP_ADD; A = 16'h1234; B = 16'h1111; CIN = 1'b0;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    check("abort_result", RESULT, 0);
    check("abort_flags", {COUT, OVERFLOW, ZERO}, 0);
    check("abort_out_valid", OUT_VALID, 0);
    check("abort_in_ready", IN_READY, 1);
    sb.delete();
    $display("reset asserted mid-RUN: result=%04h out_valid=%0b in_ready=%0b",
             RESULT, OUT_VALID, IN_READY);
    @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    saw_valid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge CLK); #1;
      if (OUT_VALID !== 1'b0) saw_valid = 1'b1;
    end
    check("abort_no_out_valid", saw_valid, 0);

    run_op("post_reset", OP_ADD, 16'h00FF, 16'h0001, 1'b0, '{16'h0100, 1'b0, 1'b0, 1'b0}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
